// File: rtl/ex_hazard_ctrl.sv
// Execute-stage sequencing controller: inserts one load-use bubble, flushes
// wrong-path instructions on taken branches, freezes the pipeline during
// data-memory stalls, latches HALT, and keeps saturating stall/flush counters.
module ex_hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      IFID_Instr,
  input  logic             IFID_ValidRs,
  input  logic             IFID_ValidRt,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWriteEN,
  input  logic [REG_W-1:0] IDEX_DstRegNum,
  input  logic             EX_BranchTaken,
  input  logic             Mem_Stall,
  input  logic             WB_Halt,
  output logic             PC_WriteEN,
  output logic             IFID_WriteEN,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             EXMEM_WriteEN,
  output logic             MEMWB_WriteEN,
  output logic             Halted,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LU_STALL   = 2'd1,
    S_MEM_FREEZE = 2'd2,
    S_HALT       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic             stall_inc;
  logic             flush_inc;
  logic             lu;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             unused_instr;

  assign rs = IFID_Instr[8 +: REG_W];
  assign rt = IFID_Instr[5 +: REG_W];
  assign unused_instr = ^{IFID_Instr[15:11], IFID_Instr[4:0]};

  // A load in ID/EX whose destination feeds a source read in IF/ID cannot be
  // forwarded in time, so it needs one bubble.
  assign lu = IDEX_MemRead & IDEX_RegWriteEN &
              ((IFID_ValidRs & (rs == IDEX_DstRegNum)) |
               (IFID_ValidRt & (rt == IDEX_DstRegNum)));

  assign Halted = (state == S_HALT);

  // Control outputs, next state and counter increments from state and inputs.
  always_comb begin
    PC_WriteEN    = 1'b1;
    IFID_WriteEN  = 1'b1;
    IFID_Flush    = 1'b0;
    IDEX_Bubble   = 1'b0;
    EXMEM_WriteEN = 1'b1;
    MEMWB_WriteEN = 1'b1;
    state_nxt     = state;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    case (state)
      S_RUN: begin
        if (WB_Halt || Mem_Stall) begin
          PC_WriteEN    = 1'b0;
          IFID_WriteEN  = 1'b0;
          EXMEM_WriteEN = 1'b0;
          MEMWB_WriteEN = 1'b0;
          state_nxt     = WB_Halt ? S_HALT : S_MEM_FREEZE;
        end else if (EX_BranchTaken) begin
          // The instruction behind a taken branch is wrong-path, so a pending
          // load-use stall on it is moot.
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          flush_inc   = 1'b1;
        end else if (lu) begin
          PC_WriteEN   = 1'b0;
          IFID_WriteEN = 1'b0;
          IDEX_Bubble  = 1'b1;
          stall_inc    = 1'b1;
          state_nxt    = S_LU_STALL;
        end
      end
      S_LU_STALL: begin
        // The load has moved on to MEM; forwarding covers it, so lu is ignored.
        if (WB_Halt || Mem_Stall) begin
          PC_WriteEN    = 1'b0;
          IFID_WriteEN  = 1'b0;
          EXMEM_WriteEN = 1'b0;
          MEMWB_WriteEN = 1'b0;
          state_nxt     = WB_Halt ? S_HALT : S_MEM_FREEZE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_MEM_FREEZE: begin
        PC_WriteEN    = 1'b0;
        IFID_WriteEN  = 1'b0;
        EXMEM_WriteEN = 1'b0;
        MEMWB_WriteEN = 1'b0;
        if (WB_Halt)         state_nxt = S_HALT;
        else if (!Mem_Stall) state_nxt = S_RUN;
      end
      default: begin
        PC_WriteEN    = 1'b0;
        IFID_WriteEN  = 1'b0;
        EXMEM_WriteEN = 1'b0;
        MEMWB_WriteEN = 1'b0;
      end
    endcase
  end

  // State register and saturating debug counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_RUN;
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      state <= state_nxt;
      if (stall_inc && (Stall_Count != CNT_MAX)) Stall_Count <= Stall_Count + 1'b1;
      if (flush_inc && (Flush_Count != CNT_MAX)) Flush_Count <= Flush_Count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl. A second instance with 4-bit counters
// shares the same stimulus so counter saturation is reachable in few cycles.
module tb_ex_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] IFID_Instr;
  logic        IFID_ValidRs, IFID_ValidRt;
  logic        IDEX_MemRead, IDEX_RegWriteEN;
  logic [2:0]  IDEX_DstRegNum;
  logic        EX_BranchTaken, Mem_Stall, WB_Halt;

  logic        pc_we, ifid_we, ifid_fl, idex_bub, exmem_we, memwb_we, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_we, s_ifid_we, s_ifid_fl, s_idex_bub, s_exmem_we, s_memwb_we, s_halted;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Control bundle order: {PC, IFID_WE, IFID_Flush, IDEX_Bubble, EXMEM_WE, MEMWB_WE}
  localparam logic [5:0] C_IDLE   = 6'b110011;
  localparam logic [5:0] C_STALL  = 6'b000111;
  localparam logic [5:0] C_FLUSH  = 6'b111111;
  localparam logic [5:0] C_FROZEN = 6'b000000;

  wire [5:0] ctl = {pc_we, ifid_we, ifid_fl, idex_bub, exmem_we, memwb_we};

  ex_hazard_ctrl #(.CNT_W(16), .REG_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .IFID_Instr(IFID_Instr),
    .IFID_ValidRs(IFID_ValidRs), .IFID_ValidRt(IFID_ValidRt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWriteEN(IDEX_RegWriteEN),
    .IDEX_DstRegNum(IDEX_DstRegNum), .EX_BranchTaken(EX_BranchTaken),
    .Mem_Stall(Mem_Stall), .WB_Halt(WB_Halt),
    .PC_WriteEN(pc_we), .IFID_WriteEN(ifid_we), .IFID_Flush(ifid_fl),
    .IDEX_Bubble(idex_bub), .EXMEM_WriteEN(exmem_we), .MEMWB_WriteEN(memwb_we),
    .Halted(halted), .Stall_Count(stall_cnt), .Flush_Count(flush_cnt)
  );

  ex_hazard_ctrl #(.CNT_W(4), .REG_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .IFID_Instr(IFID_Instr),
    .IFID_ValidRs(IFID_ValidRs), .IFID_ValidRt(IFID_ValidRt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWriteEN(IDEX_RegWriteEN),
    .IDEX_DstRegNum(IDEX_DstRegNum), .EX_BranchTaken(EX_BranchTaken),
    .Mem_Stall(Mem_Stall), .WB_Halt(WB_Halt),
    .PC_WriteEN(s_pc_we), .IFID_WriteEN(s_ifid_we), .IFID_Flush(s_ifid_fl),
    .IDEX_Bubble(s_idex_bub), .EXMEM_WriteEN(s_exmem_we), .MEMWB_WriteEN(s_memwb_we),
    .Halted(s_halted), .Stall_Count(s_stall_cnt), .Flush_Count(s_flush_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance past the next rising edge, then let combinational outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_load(input logic rd, input logic we, input logic [2:0] dst);
    IDEX_MemRead    = rd;
    IDEX_RegWriteEN = we;
    IDEX_DstRegNum  = dst;
  endtask

  task automatic set_ifid(input logic [2:0] rs, input logic vrs, input logic [2:0] rt, input logic vrt);
    IFID_Instr   = {5'b10101, rs, rt, 5'b01010};
    IFID_ValidRs = vrs;
    IFID_ValidRt = vrt;
  endtask

  initial begin
    rst_n = 1'b0;
    EX_BranchTaken = 1'b0;
    Mem_Stall = 1'b0;
    WB_Halt = 1'b0;
    set_load(1'b0, 1'b0, 3'd0);
    set_ifid(3'd0, 1'b0, 3'd0, 1'b0);
    tick();
    tick();
    settle();
    check("reset_ctl", ctl, C_IDLE);
    check("reset_halted", halted, 0);
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_flush_cnt", flush_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Load-use through Rs: exactly one bubble cycle, then normal flow.
    set_load(1'b1, 1'b1, 3'd3);
    set_ifid(3'd3, 1'b1, 3'd0, 1'b0);
    settle();
    check("lu_rs_ctl", ctl, C_STALL);
    tick();
    settle();
    check("lu_rs_after_ctl", ctl, C_IDLE);
    check("lu_rs_stall_cnt", stall_cnt, 1);
    set_load(1'b0, 1'b0, 3'd0);
    tick();

    // Load-use through Rt while Rs is not read.
    set_load(1'b1, 1'b1, 3'd3);
    set_ifid(3'd3, 1'b0, 3'd3, 1'b1);
    settle();
    check("lu_rt_ctl", ctl, C_STALL);
    tick();
    settle();
    check("lu_rt_after_ctl", ctl, C_IDLE);
    check("lu_rt_stall_cnt", stall_cnt, 2);
    set_load(1'b0, 1'b0, 3'd0);
    tick();

    // No false stalls: different register, not a load, load without writeback.
    set_load(1'b1, 1'b1, 3'd3);
    set_ifid(3'd3, 1'b0, 3'd4, 1'b1);
    settle();
    check("nolu_rt4_ctl", ctl, C_IDLE);
    tick();
    set_load(1'b0, 1'b1, 3'd3);
    set_ifid(3'd3, 1'b1, 3'd3, 1'b1);
    settle();
    check("nolu_nomemrd_ctl", ctl, C_IDLE);
    tick();
    set_load(1'b1, 1'b0, 3'd3);
    settle();
    check("nolu_noregwe_ctl", ctl, C_IDLE);
    tick();
    settle();
    check("nolu_stall_cnt", stall_cnt, 2);

    // Taken branch overrides a simultaneous load-use hazard.
    set_load(1'b1, 1'b1, 3'd3);
    set_ifid(3'd0, 1'b0, 3'd3, 1'b1);
    EX_BranchTaken = 1'b1;
    settle();
    check("br_over_lu_ctl", ctl, C_FLUSH);
    tick();
    EX_BranchTaken = 1'b0;
    set_load(1'b0, 1'b0, 3'd0);
    settle();
    check("br_over_lu_flush_cnt", flush_cnt, 1);
    check("br_over_lu_stall_cnt", stall_cnt, 2);
    check("br_after_ctl", ctl, C_IDLE);
    tick();

    // Memory freeze holding a taken branch; the flush happens once on release.
    EX_BranchTaken = 1'b1;
    Mem_Stall = 1'b1;
    settle();
    check("frz_c1_ctl", ctl, C_FROZEN);
    tick();
    settle();
    check("frz_c2_ctl", ctl, C_FROZEN);
    tick();
    settle();
    check("frz_c3_ctl", ctl, C_FROZEN);
    check("frz_flush_cnt", flush_cnt, 1);
    tick();
    Mem_Stall = 1'b0;
    settle();
    check("frz_release_ctl", ctl, C_FROZEN);
    tick();
    settle();
    check("frz_post_flush_ctl", ctl, C_FLUSH);
    tick();
    EX_BranchTaken = 1'b0;
    settle();
    check("frz_flush_cnt_once", flush_cnt, 2);
    check("frz_done_ctl", ctl, C_IDLE);
    tick();

    // Halt is sticky and ignores later events.
    WB_Halt = 1'b1;
    settle();
    check("halt_entry_ctl", ctl, C_FROZEN);
    tick();
    WB_Halt = 1'b0;
    EX_BranchTaken = 1'b1;
    set_load(1'b1, 1'b1, 3'd3);
    set_ifid(3'd3, 1'b1, 3'd3, 1'b1);
    settle();
    check("halt_halted", halted, 1);
    check("halt_ctl", ctl, C_FROZEN);
    tick();
    tick();
    tick();
    settle();
    check("halt_still_halted", halted, 1);
    check("halt_still_ctl", ctl, C_FROZEN);
    check("halt_stall_cnt", stall_cnt, 2);
    check("halt_flush_cnt", flush_cnt, 2);

    // One reset edge returns to RUN with cleared counters.
    EX_BranchTaken = 1'b0;
    set_load(1'b0, 1'b0, 3'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    check("rst_halted", halted, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_ctl", ctl, C_IDLE);
    tick();

    // Repeated load-use stalls: 20 stalls saturate the 4-bit instance.
    set_load(1'b1, 1'b1, 3'd5);
    set_ifid(3'd5, 1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      tick();
    end
    set_load(1'b0, 1'b0, 3'd0);
    settle();
    check("sat_small_stall_cnt", s_stall_cnt, 4'hF);
    check("sat_big_stall_cnt", stall_cnt, 20);
    check("sat_small_halted", s_halted, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Pipeline sequencing controller for the execute stage of the 5-stage core.
- Detects load-use hazards that the EX forwarding path cannot cover and inserts exactly one bubble.
- Flushes wrong-path instructions on a taken branch or jump resolved in EX.
- Freezes the whole pipeline while data memory is busy.
- Latches HALT, and keeps saturating stall and flush counters for debug.
- Sits beside the decode/execute pipeline registers and drives their write enables, bubble and flush controls.

Parameters:
CNT_W, 16, width of the stall and flush performance counters
REG_W, 3, register-number width

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
IFID_Instr  input  16  instruction in IF/ID; Rs = [10:8], Rt = [7:5]
IFID_ValidRs  input  1  IF/ID instruction reads Rs
IFID_ValidRt  input  1  IF/ID instruction reads Rt
IDEX_MemRead  input  1  ID/EX instruction is a load
IDEX_RegWriteEN  input  1  ID/EX instruction writes a register
IDEX_DstRegNum  input  3  ID/EX destination register
EX_BranchTaken  input  1  EX resolved a taken branch or jump this cycle
Mem_Stall  input  1  data memory not ready; hold the pipeline
WB_Halt  input  1  HALT instruction is in WB
PC_WriteEN  output  1  PC may update
IFID_WriteEN  output  1  IF/ID may load
IFID_Flush  output  1  load NOP into IF/ID
IDEX_Bubble  output  1  load NOP into ID/EX (clear control bits)
EXMEM_WriteEN  output  1  EX/MEM may load
MEMWB_WriteEN  output  1  MEM/WB may load
Halted  output  1  core halted (sticky)
Stall_Count  output  16  saturating count of load-use stall cycles
Flush_Count  output  16  saturating count of branch flushes

Behaviour:
- All state updates on the posedge of clk.
- When rst_n = 0 at a posedge: state = RUN, counters = 0, Halted = 0. Reset mid-operation aborts any stall, freeze or halt.
- Outputs are combinational from state and inputs. In RUN with no event: all WriteEN = 1, Flush = 0, Bubble = 0.
- States:
  - RUN: normal operation.
  - LU_STALL: the single bubble cycle has already been issued.
  - MEM_FREEZE: pipeline held for data memory.
  - HALT: stopped until reset.
- Load-use hazard, lu = IDEX_MemRead & IDEX_RegWriteEN & ((IFID_ValidRs & Rs == IDEX_DstRegNum) | (IFID_ValidRt & Rt == IDEX_DstRegNum)).
- Priority in RUN, highest first:
  1. WB_Halt: all enables 0; next state HALT.
  2. Mem_Stall: all enables 0, Bubble = 0, Flush = 0; next state MEM_FREEZE.
  3. EX_BranchTaken: PC_WriteEN = 1, IFID_Flush = 1, IDEX_Bubble = 1; Flush_Count +1; stay in RUN. A branch overrides lu because the stalled instruction is wrong-path anyway.
  4. lu: PC_WriteEN = 0, IFID_WriteEN = 0, IDEX_Bubble = 1; Stall_Count +1; next state LU_STALL.
- LU_STALL:
  - Lasts exactly one cycle; lu detection is suppressed (the load has moved to MEM and forwarding covers the dependency).
  - Outputs are as in RUN with no event.
  - Next state RUN, unless Mem_Stall (then MEM_FREEZE) or WB_Halt (then HALT).
  - EX_BranchTaken is impossible here because the bubble occupies EX.
- MEM_FREEZE:
  - All enables 0, no Bubble, no Flush; branch and lu are ignored, which preserves pipeline contents.
  - Stay while Mem_Stall = 1. WB_Halt during freeze moves to HALT.
  - When Mem_Stall drops, next state is RUN, where pending branch or lu conditions are evaluated normally.
  - A branch held in EX is therefore flushed exactly once, after the freeze.
- HALT: all enables 0, Halted = 1, no counting; exit only via reset.
- Counters saturate at 16'hFFFF and do not wrap.

Test Plan:
- Load-use stall: IDEX load, DstRegNum = 3; IFID Rs = 3, ValidRs = 1 → one cycle with PC_WriteEN = 0, IFID_WriteEN = 0, IDEX_Bubble = 1; next cycle all enables = 1; Stall_Count = 1.
- No false stall: same case but ValidRs = 0 and Rt = 3 with ValidRt = 1 → stall. Then Rt = 4 → no stall. Then IDEX_MemRead = 0 → no stall.
- Branch over hazard: EX_BranchTaken = 1 together with lu = 1 → IFID_Flush = 1, IDEX_Bubble = 1, PC_WriteEN = 1; Flush_Count = 1; Stall_Count unchanged.
- Memory freeze: Mem_Stall high for 3 cycles while EX_BranchTaken = 1 → 3 cycles with all enables 0 and no flush. On release, one flush cycle follows; Flush_Count +1 exactly once.
- Halt and reset: WB_Halt = 1 → Halted = 1 and enables 0 indefinitely. rst_n = 0 at one edge → Halted = 0, counters = 0, RUN.
- Saturation: force 65536 stalls → Stall_Count holds at 16'hFFFF.
